// File: rtl/lv2_link_pkg.sv
// Shared types and defaults for the LV2 layer-2 TLK link alignment supervisor.
package lv2_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    SETTLE = 3'd2,
    LOCKED = 3'd3,
    RETRY  = 3'd4,
    FAIL   = 3'd5
  } link_state_t;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_WAIT   = WAIT;
  localparam logic [2:0] ST_SETTLE = SETTLE;
  localparam logic [2:0] ST_LOCKED = LOCKED;
  localparam logic [2:0] ST_RETRY  = RETRY;
  localparam logic [2:0] ST_FAIL   = FAIL;

  localparam int DEF_N_LINKS        = 8;
  localparam int DEF_SETTLE_CYCLES  = 500;
  localparam int DEF_TIMEOUT_CYCLES = 65535;
  localparam int DEF_RST_PULSE      = 16;
  localparam int DEF_MAX_RETRY      = 3;

  localparam int LOCK_LOSS_W = 8;

  function automatic int cnt_w(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/link_align_fsm.sv
// One TLK link: falling-edge detect, settle/timeout timers, retry pulses, fail latch.
// Lock-loss counter is built only when LINK_ERR_CNT_EN is defined.
module link_align_fsm
  import lv2_link_pkg::*;
#(
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int RST_PULSE      = DEF_RST_PULSE,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   live,
  input  logic                   tlk_err,
  output logic                   dval,
  output logic                   tlk_rst_req,
  output logic                   link_fail,
  output logic [LOCK_LOSS_W-1:0] lock_loss_cnt
);

  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam int PW = cnt_w(RST_PULSE);
  // Retry count must reach MAX_RETRY itself, so size for MAX_RETRY+1 values.
  localparam int RW = cnt_w(MAX_RETRY + 1);

  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] P_LAST = PW'(RST_PULSE - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRY);

  logic [2:0]    state;
  logic          pipe;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic [PW-1:0] pcnt;
  logic [RW-1:0] rcnt;
  logic          fell;

  assign fell = ~tlk_err & pipe;

  always_ff @(posedge clk) begin
    if (reset || !live) begin
      state       <= ST_IDLE;
      pipe        <= 1'b0;
      tcnt        <= '0;
      scnt        <= '0;
      pcnt        <= '0;
      rcnt        <= '0;
      dval        <= 1'b0;
      tlk_rst_req <= 1'b0;
      link_fail   <= 1'b0;
    end else begin
      // The pipe stays clear in IDLE so a link already low at LIVE rise shows no edge.
      pipe <= (state == ST_IDLE) ? 1'b0 : tlk_err;
      case (state)
        ST_IDLE: begin
          state <= ST_WAIT;
          tcnt  <= '0;
          rcnt  <= '0;
        end
        ST_WAIT: begin
          if (fell) begin
            state <= ST_SETTLE;
            scnt  <= '0;
          end else if (tcnt == T_LAST) begin
            state       <= ST_RETRY;
            rcnt        <= rcnt + 1'b1;
            pcnt        <= '0;
            tlk_rst_req <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tlk_err) begin
            state <= ST_WAIT;
            tcnt  <= '0;
          end else if (scnt == S_LAST) begin
            state <= ST_LOCKED;
            dval  <= 1'b1;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (tlk_err) begin
            state <= ST_WAIT;
            tcnt  <= '0;
            dval  <= 1'b0;
          end
        end
        ST_RETRY: begin
          if (pcnt == P_LAST) begin
            tlk_rst_req <= 1'b0;
            tcnt        <= '0;
            if (rcnt == R_MAX) begin
              state     <= ST_FAIL;
              link_fail <= 1'b1;
            end else begin
              state <= ST_WAIT;
            end
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        ST_FAIL: state <= ST_FAIL;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LINK_ERR_CNT_EN
  // Only reset clears the history; LIVE drops keep it for diagnostics.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_loss_cnt <= '0;
    end else if (live && (state == ST_LOCKED) && tlk_err && (lock_loss_cnt != '1)) begin
      lock_loss_cnt <= lock_loss_cnt + 1'b1;
    end
  end
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: rtl/link_align_ctrl.sv
// Supervises N_LINKS TLK receivers and produces the registered all-links-valid gate.
// Per-link lock-loss counters exist only when LINK_ERR_CNT_EN is defined.
module link_align_ctrl
  import lv2_link_pkg::*;
#(
  parameter int N_LINKS        = DEF_N_LINKS,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int RST_PULSE      = DEF_RST_PULSE,
  parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           LIVE,
  input  logic [N_LINKS-1:0]             tlk_err,
  output logic [N_LINKS-1:0]             dval,
  output logic                           all_dval,
  output logic [N_LINKS-1:0]             tlk_rst_req,
  output logic [N_LINKS-1:0]             link_fail,
  output logic [LOCK_LOSS_W*N_LINKS-1:0] lock_loss_cnt
);

  for (genvar i = 0; i < N_LINKS; i++) begin : g_link
    link_align_fsm #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .RST_PULSE     (RST_PULSE),
      .MAX_RETRY     (MAX_RETRY)
    ) u_fsm (
      .clk          (clk),
      .reset        (reset),
      .live         (LIVE),
      .tlk_err      (tlk_err[i]),
      .dval         (dval[i]),
      .tlk_rst_req  (tlk_rst_req[i]),
      .link_fail    (link_fail[i]),
      .lock_loss_cnt(lock_loss_cnt[i*LOCK_LOSS_W +: LOCK_LOSS_W])
    );
  end

  // Registered so the event-builder gate is glitch-free; lags dval by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      all_dval <= 1'b0;
    end else begin
      all_dval <= &dval;
    end
  end

endmodule

// File: tb/tb_link_align_ctrl.sv
// Self-checking bench for link_align_ctrl: directed vector table, hand sequences,
// and randomized stimulus checked against a timestamp-based reference model.
module tb_link_align_ctrl;

  localparam int N  = 4;
  localparam int S  = 50;
  localparam int T  = 100;
  localparam int P  = 16;
  localparam int MR = 3;

`ifdef LINK_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             LIVE;
  logic [N-1:0]     tlk_err;
  logic [N-1:0]     dval;
  logic             all_dval;
  logic [N-1:0]     tlk_rst_req;
  logic [N-1:0]     link_fail;
  logic [8*N-1:0]   lock_loss_cnt;

  link_align_ctrl #(
    .N_LINKS       (N),
    .SETTLE_CYCLES (S),
    .TIMEOUT_CYCLES(T),
    .RST_PULSE     (P),
    .MAX_RETRY     (MR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .LIVE         (LIVE),
    .tlk_err      (tlk_err),
    .dval         (dval),
    .all_dval     (all_dval),
    .tlk_rst_req  (tlk_rst_req),
    .link_fail    (link_fail),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model: each link remembers its phase and the cycle that phase began.
  typedef enum int {M_IDLE, M_WAIT, M_SETTLE, M_LOCKED, M_RETRY, M_FAIL} mode_t;
  mode_t m_mode    [N];
  int    m_since   [N];
  int    m_retries [N];
  int    m_ll      [N];
  bit    m_prev    [N];
  bit    m_all;

  function automatic logic [N-1:0] m_vec(input mode_t which);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = (m_mode[i] == which);
    return v;
  endfunction

  function automatic logic [8*N-1:0] m_llc();
    logic [8*N-1:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = 8'(m_ll[i]);
    return v;
  endfunction

  task automatic enter(input int i, input mode_t m);
    m_mode[i]  = m;
    m_since[i] = cyc;
  endtask

  task automatic model_edge();
    logic [N-1:0] old_dval;
    cyc++;
    old_dval = m_vec(M_LOCKED);
    if (reset) begin
      m_all = 1'b0;
      for (int i = 0; i < N; i++) begin
        enter(i, M_IDLE);
        m_prev[i] = 1'b0; m_retries[i] = 0; m_ll[i] = 0;
      end
    end else begin
      m_all = &old_dval;
      for (int i = 0; i < N; i++) begin
        if (!LIVE) begin
          enter(i, M_IDLE);
          m_prev[i] = 1'b0; m_retries[i] = 0;
        end else begin
          int age;
          bit e, fell, was_idle;
          age      = cyc - m_since[i];
          e        = tlk_err[i];
          fell     = !e && m_prev[i];
          was_idle = (m_mode[i] == M_IDLE);
          case (m_mode[i])
            M_IDLE: begin enter(i, M_WAIT); m_retries[i] = 0; end
            M_WAIT: begin
              if (fell) enter(i, M_SETTLE);
              else if (age == T) begin m_retries[i]++; enter(i, M_RETRY); end
            end
            M_SETTLE: begin
              if (e) enter(i, M_WAIT);
              else if (age == S) enter(i, M_LOCKED);
            end
            M_LOCKED: begin
              if (e) begin
                enter(i, M_WAIT);
                if (CNT_EN && m_ll[i] < 255) m_ll[i]++;
              end
            end
            M_RETRY: if (age == P) enter(i, (m_retries[i] == MR) ? M_FAIL : M_WAIT);
            default: ;
          endcase
          m_prev[i] = was_idle ? 1'b0 : e;
        end
      end
    end
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock: model follows the DUT edge, outputs compared at the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_output("model.dval", 64'(dval), 64'(m_vec(M_LOCKED)));
    check_output("model.all_dval", 64'(all_dval), 64'(m_all));
    check_output("model.tlk_rst_req", 64'(tlk_rst_req), 64'(m_vec(M_RETRY)));
    check_output("model.link_fail", 64'(link_fail), 64'(m_vec(M_FAIL)));
    check_output("model.lock_loss_cnt", 64'(lock_loss_cnt), 64'(m_llc()));
  endtask

  task automatic apply_stimulus(input bit r, input bit l, input logic [N-1:0] e);
    reset   = r;
    LIVE    = l;
    tlk_err = e;
  endtask

  typedef struct {
    bit           rst;
    bit           live;
    logic [N-1:0] err;
    int           cycles;
    logic [N-1:0] e_dval;
    bit           e_all;
    logic [N-1:0] e_rst;
    logic [N-1:0] e_fail;
    int           ll0;
    int           ll1;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input bit r, input bit l, input logic [N-1:0] e, input int k,
                         input logic [N-1:0] d, input bit a, input logic [N-1:0] q,
                         input logic [N-1:0] f, input int l0, input int l1);
    vec_t v;
    v.rst = r; v.live = l; v.err = e; v.cycles = k;
    v.e_dval = d; v.e_all = a; v.e_rst = q; v.e_fail = f; v.ll0 = l0; v.ll1 = l1;
    tbl.push_back(v);
  endtask

  function automatic logic [8*N-1:0] exp_llc(input int l0, input int l1, input int l3);
    logic [8*N-1:0] v;
    v = '0;
    v[7:0]   = CNT_EN ? 8'(l0) : 8'd0;
    v[15:8]  = CNT_EN ? 8'(l1) : 8'd0;
    v[31:24] = CNT_EN ? 8'(l3) : 8'd0;
    return v;
  endfunction

  initial begin
    apply_stimulus(1'b1, 1'b0, '1);

    //      rst live err    k    dval   all  rst    fail  ll0 ll1
    add_row(1, 0, 4'hF,   2,   4'h0, 0, 4'h0, 4'h0, 0, 0);
    add_row(0, 1, 4'hF,   1,   4'h0, 0, 4'h0, 4'h0, 0, 0);
    add_row(0, 1, 4'hF,   1,   4'h0, 0, 4'h0, 4'h0, 0, 0);
    add_row(0, 1, 4'h0,   1,   4'h0, 0, 4'h0, 4'h0, 0, 0);
    add_row(0, 1, 4'h0,  48,   4'h0, 0, 4'h0, 4'h0, 0, 0);
    add_row(0, 1, 4'h0,   1,   4'h0, 0, 4'h0, 4'h0, 0, 0);
    add_row(0, 1, 4'h0,   1,   4'hF, 0, 4'h0, 4'h0, 0, 0);
    add_row(0, 1, 4'h0,   1,   4'hF, 1, 4'h0, 4'h0, 0, 0);
    add_row(0, 1, 4'h1,   1,   4'hE, 1, 4'h0, 4'h0, 1, 0);
    add_row(0, 1, 4'h0,   1,   4'hE, 0, 4'h0, 4'h0, 1, 0);
    add_row(0, 1, 4'h0,  49,   4'hE, 0, 4'h0, 4'h0, 1, 0);
    add_row(0, 1, 4'h0,   1,   4'hF, 0, 4'h0, 4'h0, 1, 0);
    add_row(0, 1, 4'h0,   1,   4'hF, 1, 4'h0, 4'h0, 1, 0);
    add_row(0, 1, 4'h2,   1,   4'hD, 1, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,   1,   4'hD, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,  30,   4'hD, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h2,   1,   4'hD, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,   1,   4'hD, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,  49,   4'hD, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,   1,   4'hF, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 0, 4'h0,   1,   4'h0, 1, 4'h0, 4'h0, 1, 1);
    add_row(0, 0, 4'h0,   1,   4'h0, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,   1,   4'h0, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,  98,   4'h0, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,   1,   4'h0, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,   1,   4'h0, 0, 4'hF, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,  15,   4'h0, 0, 4'hF, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,   1,   4'h0, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0, 100,   4'h0, 0, 4'hF, 4'h0, 1, 1);
    add_row(0, 1, 4'h0, 116,   4'h0, 0, 4'hF, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,  16,   4'h0, 0, 4'h0, 4'hF, 1, 1);
    add_row(0, 1, 4'h0,  50,   4'h0, 0, 4'h0, 4'hF, 1, 1);
    add_row(0, 0, 4'h0,   1,   4'h0, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,   1,   4'h0, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0, 105,   4'h0, 0, 4'hF, 4'h0, 1, 1);
    add_row(0, 0, 4'h0,   1,   4'h0, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'hF,   1,   4'h0, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'hF,  99,   4'h0, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,   1,   4'h0, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,  49,   4'h0, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,   1,   4'hF, 0, 4'h0, 4'h0, 1, 1);
    add_row(0, 1, 4'h0,   1,   4'hF, 1, 4'h0, 4'h0, 1, 1);

    foreach (tbl[r]) begin
      apply_stimulus(tbl[r].rst, tbl[r].live, tbl[r].err);
      repeat (tbl[r].cycles) step();
      check_output($sformatf("row%0d.dval", r), 64'(dval), 64'(tbl[r].e_dval));
      check_output($sformatf("row%0d.all_dval", r), 64'(all_dval), 64'(tbl[r].e_all));
      check_output($sformatf("row%0d.tlk_rst_req", r), 64'(tlk_rst_req), 64'(tbl[r].e_rst));
      check_output($sformatf("row%0d.link_fail", r), 64'(link_fail), 64'(tbl[r].e_fail));
      check_output($sformatf("row%0d.lock_loss_cnt", r), 64'(lock_loss_cnt),
                   64'(exp_llc(tbl[r].ll0, tbl[r].ll1, 0)));
    end

    // Lock-loss saturation: 300 single-cycle error pulses on locked link 3.
    for (int k = 0; k < 300; k++) begin
      apply_stimulus(1'b0, 1'b1, 4'h8);
      step();
      check_output("sat.dval_drop", 64'(dval), 64'(4'h7));
      apply_stimulus(1'b0, 1'b1, 4'h0);
      repeat (S + 1) step();
      check_output("sat.relock", 64'(dval), 64'(4'hF));
    end
    check_output("sat.lock_loss_cnt", 64'(lock_loss_cnt), 64'(exp_llc(1, 1, 255)));

    // LIVE drop keeps the counters; reset clears them.
    apply_stimulus(1'b0, 1'b0, 4'h0);
    step();
    check_output("live_drop.keep_cnt", 64'(lock_loss_cnt), 64'(exp_llc(1, 1, 255)));
    check_output("live_drop.dval", 64'(dval), 64'(0));
    apply_stimulus(1'b1, 1'b0, 4'h0);
    step();
    check_output("reset.clear_cnt", 64'(lock_loss_cnt), 64'(0));
    check_output("reset.all_dval", 64'(all_dval), 64'(0));

    // Randomized traffic: rare error toggles, LIVE drops and resets.
    apply_stimulus(1'b0, 1'b1, 4'hF);
    for (int k = 0; k < 8000; k++) begin
      logic [N-1:0] flip;
      for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 69) == 0);
      tlk_err = tlk_err ^ flip;
      reset   = ($urandom_range(0, 1999) == 0);
      if (LIVE && $urandom_range(0, 399) == 0) LIVE = 1'b0;
      else if (!LIVE && $urandom_range(0, 7) == 0) LIVE = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
